// File: rtl/mac_stream_pkg.sv
// Shared types and timing constants for the MAC stream controller.
package mac_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int MEM_LAT      = 1;
  localparam int MAC_LAT      = 1;
  localparam int DRAIN_CYCLES = MEM_LAT + MAC_LAT;

endpackage

// File: rtl/mac_stream_addr_gen.sv
// Operand address generator: latches job bases/length, walks the index and
// flags the last read of the job.
module mac_stream_addr_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_a_i,
  input  logic [ADDR_WIDTH-1:0] base_b_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  go,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  rd_en,
  output logic                  last,
  output logic                  len_zero
);

  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic                  active_q, active_d;

  // Addresses wrap naturally through the fixed-width adders.
  assign addr_a   = base_a_q + ADDR_WIDTH'(idx_q);
  assign addr_b   = base_b_q + ADDR_WIDTH'(idx_q);
  assign rd_en    = active_q;
  assign last     = active_q && (idx_q == LEN_WIDTH'(len_q - 1'b1));
  assign len_zero = (len_q == '0);

  always_comb begin
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    len_d    = len_q;
    idx_d    = idx_q;
    active_d = active_q;
    if (load) begin
      base_a_d = base_a_i;
      base_b_d = base_b_i;
      len_d    = len_i;
    end
    if (go) begin
      idx_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last) active_d = 1'b0;
      else      idx_d    = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_a_q <= '0;
      base_b_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/mac_stream_ctrl.sv
// Dot-product job sequencer feeding one MAC lane from two operand buffers.
// Optional zero-operand pair counter enabled by MAC_STREAM_ZERO_CNT_EN.
module mac_stream_ctrl
  import mac_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] start_base_a,
  input  logic [ADDR_WIDTH-1:0] start_base_b,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_a,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  input  logic [DATA_WIDTH-1:0] mem_data_a,
  input  logic [DATA_WIDTH-1:0] mem_data_b,
  output logic                  mac_clear,
  output logic                  mac_valid,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_acc,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
`ifdef MAC_STREAM_ZERO_CNT_EN
  output logic [LEN_WIDTH-1:0]  res_zero_cnt,
`endif
  output state_e                dbg_state,
  output logic                  busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and a presented result holds until taken.

  state_e                state_q, state_d;
  logic [1:0]            drain_cnt_q, drain_cnt_d;
  logic                  mac_clear_q, mac_clear_d;
  logic                  mac_valid_q, mac_valid_d;
  logic                  res_valid_q, res_valid_d;
  logic [ACC_WIDTH-1:0]  res_data_q, res_data_d;
  logic                  start_ready_q, start_ready_d;
  logic                  busy_q, busy_d;
  logic                  load, go, last, len_zero, rd_en;

  mac_stream_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .base_a_i (start_base_a),
    .base_b_i (start_base_b),
    .len_i    (start_len),
    .go       (go),
    .addr_a   (mem_addr_a),
    .addr_b   (mem_addr_b),
    .rd_en    (rd_en),
    .last     (last),
    .len_zero (len_zero)
  );

`ifdef MAC_STREAM_ZERO_CNT_EN
  logic [LEN_WIDTH-1:0] zero_cnt_q, zero_cnt_d;
  logic [LEN_WIDTH-1:0] res_zero_cnt_q, res_zero_cnt_d;
  assign res_zero_cnt = res_zero_cnt_q;
`endif

  assign mem_rd_en   = rd_en;
  assign mac_a       = mem_data_a;
  assign mac_b       = mem_data_b;
  assign mac_clear   = mac_clear_q;
  assign mac_valid   = mac_valid_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    load        = 1'b0;
    go          = 1'b0;
`ifdef MAC_STREAM_ZERO_CNT_EN
    res_zero_cnt_d = res_zero_cnt_q;
    zero_cnt_d     = zero_cnt_q;
    if (state_q == ST_CLEAR)
      zero_cnt_d = '0;
    else if (mac_valid_q && (mem_data_a == '0 || mem_data_b == '0))
      zero_cnt_d = zero_cnt_q + 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          load    = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        drain_cnt_d = '0;
        if (len_zero) begin
          state_d = ST_DRAIN;
        end else begin
          go      = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Last pair lands in the MAC during the first drain cycle.
        if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          res_data_d  = mac_acc;
`ifdef MAC_STREAM_ZERO_CNT_EN
          res_zero_cnt_d = zero_cnt_d;
`endif
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mac_clear_d   = (state_d == ST_CLEAR);
    mac_valid_d   = rd_en;
    start_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= '0;
      mac_clear_q   <= 1'b0;
      mac_valid_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
`ifdef MAC_STREAM_ZERO_CNT_EN
      zero_cnt_q     <= '0;
      res_zero_cnt_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      mac_clear_q   <= mac_clear_d;
      mac_valid_q   <= mac_valid_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
`ifdef MAC_STREAM_ZERO_CNT_EN
      zero_cnt_q     <= zero_cnt_d;
      res_zero_cnt_q <= res_zero_cnt_d;
`endif
    end
  end

endmodule
